// File: rtl/axi2mem_r_buffer.sv
`default_nettype none
// ============================================================================
// Module      : axi2mem_r_buffer
// Description : Elastic in-order FIFO on the AXI read-data (R) channel of the
//               axi2mem bridge. Beats from the memory-side read unit (slave
//               side) are packed {DATA,RESP,ID,USER,LAST} into DEPTH entries
//               and replayed to the AXI R port (master side). The FIFO sustains
//               one beat per cycle. slave_ready_o depends only on registered
//               state, so there is no combinational path from master_ready_i
//               back to slave_ready_o.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         synchronous active-low reset
//   slave_valid_i  read beat valid (memory side)
//   slave_data_i   RDATA          slave_resp_i  RRESP
//   slave_id_i     RID            slave_user_i  RUSER
//   slave_last_i   RLAST
//   slave_ready_o  buffer can accept a beat
//   master_valid_o RVALID         master_data_o RDATA
//   master_resp_o  RRESP          master_id_o   RID
//   master_user_o  RUSER          master_last_o RLAST
//   master_ready_i RREADY
//   count_o        number of occupied entries
// ============================================================================
module axi2mem_r_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 6,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slave_valid_i,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  logic [1:0]            slave_resp_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  input  logic                  slave_last_i,
  output logic                  slave_ready_o,
  output logic                  master_valid_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [1:0]            master_resp_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic                  master_last_o,
  input  logic                  master_ready_i,
  output logic [CNT_WIDTH-1:0]  count_o
);

  localparam int ENTRY_W = DATA_WIDTH + 2 + ID_WIDTH + USER_WIDTH + 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  // Registered "not full" flag; held low by reset so the slave side only
  // opens in the cycle after the first edge that sees rst_ni released.
  logic                 ready_q, ready_d;

  logic                 push, pop;
  logic [ENTRY_W-1:0]   wr_entry, rd_entry;

  // rst_ni gates ready so the slave side is closed for the whole reset
  // window; this does not involve master_ready_i.
  assign slave_ready_o  = ready_q & rst_ni;
  assign master_valid_o = (count_q != '0);

  assign push = slave_valid_i & slave_ready_o;
  assign pop  = master_valid_o & master_ready_i;

  assign wr_entry = {slave_data_i, slave_resp_i, slave_id_i, slave_user_i, slave_last_i};
  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    if (push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage is not reset; it is only written on an accepted beat, so
  // unknown payload presented with slave_valid_i low never lands here.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Payload is forced to zero when empty so stale entries never show.
  always_comb begin
    master_data_o = '0;
    master_resp_o = '0;
    master_id_o   = '0;
    master_user_o = '0;
    master_last_o = 1'b0;
    if (master_valid_o) begin
      {master_data_o, master_resp_o, master_id_o, master_user_o, master_last_o} = rd_entry;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_axi2mem_r_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi2mem_r_buffer
// Description : Self-checking bench for axi2mem_r_buffer. A queue-based
//               model of an in-order DEPTH-entry buffer is compared against
//               every DUT output on each falling edge; directed scenarios
//               add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi2mem_r_buffer;

  localparam int DW    = 64;
  localparam int IW    = 4;
  localparam int UW    = 6;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic [IW-1:0] id;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   = 1'b0;
  logic          s_valid = 1'b0;
  beat_t         s_beat  = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    m_resp;
  logic [IW-1:0] m_id;
  logic [UW-1:0] m_user;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic [CW-1:0] count;

  axi2mem_r_buffer #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slave_valid_i(s_valid), .slave_data_i(s_beat.data), .slave_resp_i(s_beat.resp),
    .slave_id_i(s_beat.id), .slave_user_i(s_beat.user), .slave_last_i(s_beat.last),
    .slave_ready_o(s_ready),
    .master_valid_o(m_valid), .master_data_o(m_data), .master_resp_o(m_resp),
    .master_id_o(m_id), .master_user_o(m_user), .master_last_o(m_last),
    .master_ready_i(m_ready), .count_o(count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  beat_t mq[$];
  bit    live   = 0;   // an edge has seen reset released
  bit    chk_en = 0;
  bit    m_push, m_pop;

  always @(posedge clk) begin
    m_push = s_valid && rst_n && live && (mq.size() < DEPTH);
    m_pop  = (mq.size() != 0) && m_ready;
    if (!rst_n) begin
      mq.delete();
      live = 0;
    end else begin
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(s_beat);
      live = 1;
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      beat_t e;
      e = (mq.size() != 0) ? mq[0] : '0;
      check("slave_ready", 64'(s_ready), 64'(rst_n && live && (mq.size() < DEPTH)));
      check("m_valid", 64'(m_valid), 64'(mq.size() != 0));
      check("m_data",  m_data, e.data);
      check("m_resp",  64'(m_resp), 64'(e.resp));
      check("m_id",    64'(m_id),   64'(e.id));
      check("m_user",  64'(m_user), 64'(e.user));
      check("m_last",  64'(m_last), 64'(e.last));
      check("count",   64'(count),  64'(mq.size()));
    end
  end

  // ---------------- log of beats the DUT delivers ----------------
  beat_t dlog[$];
  int    dcyc[$];
  int    cyc = 0;
  always @(posedge clk) begin
    cyc++;
    if (rst_n && m_valid && m_ready) begin
      dlog.push_back('{m_data, m_resp, m_id, m_user, m_last});
      dcyc.push_back(cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [1:0] r, input logic [IW-1:0] i,
                       input logic [UW-1:0] u, input logic l);
    s_valid = 1'b1;
    s_beat  = '{d, r, i, u, l};
  endtask

  // Garbage payload while invalid: must never reach the master side.
  task automatic idle();
    s_valid = 1'b0;
    s_beat  = '{{$urandom, $urandom}, 2'($urandom), IW'($urandom), UW'($urandom), 1'($urandom)};
  endtask

  // Hold a beat until it is accepted (bounded).
  task automatic push_hold(input logic [DW-1:0] d, input logic [1:0] r, input logic last);
    bit done = 0;
    drive(d, r, 4'h1, 6'h05, last);
    for (int k = 0; k < 20 && !done; k++) begin
      done = s_ready;
      step();
    end
    check("push_accept_timeout", 64'(done), 64'd1);
    idle();
  endtask

  initial begin
    // Reset with valid asserted
    drive(64'h1111, 2'd0, 4'd1, 6'd1, 1'b1);
    m_ready = 1'b1;
    repeat (3) step();
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_data",  m_data, 64'd0);
    rst_n = 1'b1;
    idle();
    step();
    check("release_ready", 64'(s_ready), 64'd1);

    // Single beat
    drive(64'hDEADBEEF_0000_0001, 2'd0, 4'd3, 6'h2A, 1'b1);
    step();
    idle();
    check("single_valid", 64'(m_valid), 64'd1);
    check("single_data",  m_data, 64'hDEADBEEF_0000_0001);
    check("single_id",    64'(m_id), 64'd3);
    check("single_user",  64'(m_user), 64'h2A);
    check("single_last",  64'(m_last), 64'd1);
    check("single_count", 64'(count), 64'd1);
    step();
    check("single_drained", 64'(count), 64'd0);

    // Streaming 16 beats
    dlog.delete(); dcyc.delete();
    for (int i = 0; i < 16; i++) begin
      drive(64'(i), 2'd0, 4'd2, 6'd0, i == 15);
      step();
    end
    idle();
    repeat (3) step();
    check("stream_n", 64'(dlog.size()), 64'd16);
    if (dlog.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check("stream_data", dlog[i].data, 64'(i));
        check("stream_last", 64'(dlog[i].last), 64'(i == 15));
      end
      check("stream_span", 64'(dcyc[15] - dcyc[0]), 64'd15);
    end

    // Back-pressure
    dlog.delete();
    m_ready = 1'b0;
    drive(64'd100, 2'd0, 4'd1, 6'd5, 1'b0); step();
    drive(64'd101, 2'd0, 4'd1, 6'd5, 1'b0); step();
    drive(64'd102, 2'd0, 4'd1, 6'd5, 1'b1); step(); step();
    check("bp_count", 64'(count), 64'd2);
    check("bp_ready", 64'(s_ready), 64'd0);
    check("bp_hold",  m_data, 64'd100);
    m_ready = 1'b1;
    push_hold(64'd102, 2'd0, 1'b1);
    repeat (3) step();
    check("bp_n", 64'(dlog.size()), 64'd3);
    if (dlog.size() == 3)
      for (int i = 0; i < 3; i++) check("bp_order", dlog[i].data, 64'(100 + i));

    // Simultaneous push/pop with SLVERR on second beat
    dlog.delete();
    drive(64'hA0, 2'd0, 4'd7, 6'd1, 1'b0); step();
    check("sim_count1", 64'(count), 64'd1);
    drive(64'hB0, 2'd2, 4'd7, 6'd2, 1'b1); step();
    idle();
    check("sim_count_stay", 64'(count), 64'd1);
    check("sim_resp_live", 64'(m_resp), 64'd2);
    repeat (2) step();
    check("sim_n", 64'(dlog.size()), 64'd2);
    if (dlog.size() == 2) begin
      check("sim_first",  dlog[0].data, 64'hA0);
      check("sim_resp0",  64'(dlog[0].resp), 64'd0);
      check("sim_second", dlog[1].data, 64'hB0);
      check("sim_resp1",  64'(dlog[1].resp), 64'd2);
    end

    // Reset mid-burst
    m_ready = 1'b0;
    drive(64'hC0, 2'd0, 4'd4, 6'd3, 1'b0); step();
    drive(64'hC1, 2'd0, 4'd4, 6'd3, 1'b0); step();
    idle();
    check("mid_count", 64'(count), 64'd2);
    rst_n = 1'b0;
    step();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    rst_n = 1'b1;
    step();
    dlog.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_hold(64'hE0 + 64'(i), 2'd1, i == 3);
    repeat (3) step();
    check("mid_n", 64'(dlog.size()), 64'd4);
    if (dlog.size() == 4)
      for (int i = 0; i < 4; i++) check("mid_data", dlog[i].data, 64'hE0 + 64'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi2mem_r_buffer.md
Name: axi2mem_r_buffer

Overview:
Elastic buffer on the AXI read-data (R) channel of the axi2mem bridge. Sits between the memory-side read unit (slave side: produces read beats) and the AXI R port (master side: returns beats to the AXI initiator). It decouples memory read latency from R-channel back-pressure. It packs DATA/RESP/ID/USER/LAST into a DEPTH-entry in-order FIFO that sustains one beat per cycle. No combinational path runs from master_ready_i to slave_ready_o.

Parameters:
DATA_WIDTH, 64, R data width in bits
ID_WIDTH, 4, RID width
USER_WIDTH, 6, RUSER width
DEPTH, 2, number of FIFO entries; power of two, >= 2
CNT_WIDTH, $clog2(DEPTH+1), width of count_o (derived, do not override)

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  reset, synchronous, active-low
slave_valid_i  in  1  read beat valid from the memory-side read unit
slave_data_i  in  DATA_WIDTH  read data
slave_resp_i  in  2  RRESP code (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
slave_id_i  in  ID_WIDTH  RID
slave_user_i  in  USER_WIDTH  RUSER
slave_last_i  in  1  last beat of the burst
slave_ready_o  out  1  buffer can accept a beat
master_valid_o  out  1  RVALID
master_data_o  out  DATA_WIDTH  RDATA
master_resp_o  out  2  RRESP
master_id_o  out  ID_WIDTH  RID
master_user_o  out  USER_WIDTH  RUSER
master_last_o  out  1  RLAST
master_ready_i  in  1  RREADY
count_o  out  CNT_WIDTH  number of occupied entries

Behaviour:
- Reset: rst_ni sampled low at a rising edge clears wr_ptr, rd_ptr and count to 0. Storage RAM is not reset.
- Reset outputs: during and after reset, master_valid_o=0, all master payload outputs=0, count_o=0. slave_ready_o=0 while rst_ni is low and 1 from the first cycle after release.
- Push occurs when slave_valid_i && slave_ready_o. The packed beat is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop occurs when master_valid_o && master_ready_i. rd_ptr increments modulo DEPTH.
- Count update: push only gives count+1; pop only gives count-1; push and pop together leave count unchanged.
- slave_ready_o = (count != DEPTH) && rst_ni released. It is a function of registered state only.
- master_valid_o = (count != 0). When count != 0, master_* payload = entry at rd_ptr. When empty, all master payload outputs = 0.
- Latency: a beat pushed at edge N is visible on the master side in the cycle after edge N. There is no same-cycle bypass.
- Throughput: with master_ready_i held high and slave_valid_i held high, one beat per cycle is transferred, with no bubbles after the first.
- Full (count=DEPTH): slave_ready_o=0, so no push is possible even if a pop occurs that cycle. slave_ready_o returns to 1 in the cycle after the pop.
- Empty (count=0): a pop is impossible. A push while empty sets count to 1.
- Ordering: strict FIFO. Payload fields of one beat are never mixed with fields of another beat.
- Field handling: RESP, ID, USER and LAST pass through unmodified. The buffer does no interleave or ID reordering.
- Master-side hold: while master_valid_o=1 and master_ready_i=0, all master outputs stay stable (AXI rule).
- Pointer wrap: pointers wrap DEPTH-1 to 0 with no lost or duplicated beat.
- Reset mid-burst: any buffered beats are discarded. master_valid_o falls in the cycle after the reset edge. The burst restarts cleanly after release.
- Inputs: X on payload inputs while slave_valid_i=0 must not propagate to master outputs.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with slave_valid_i=1 -> master_valid_o=0, slave_ready_o=0, count_o=0. One cycle after release, slave_ready_o=1.
- Single beat: push data=0xDEADBEEF_0000_0001, resp=0, id=3, user=0x2A, last=1 at edge N -> master_valid_o=1 with identical fields in the cycle after N. Pop with ready=1 -> count_o returns to 0.
- Streaming: 16-beat burst, data=0..15, last on beat 15, master_ready_i=1 throughout -> 16 beats out in 16 consecutive cycles, in order, last only on data=15.
- Back-pressure: master_ready_i=0, push 3 beats (DEPTH=2) -> only 2 accepted, slave_ready_o=0, count_o=2, master outputs stable. Raise ready -> beats 0,1,2 drained in order.
- Simultaneous push and pop at count_o=1, resp=2 (SLVERR) on the second beat -> count_o stays 1. Output order is preserved and RRESP=2 is delivered on the correct beat.
- Reset mid-burst: 2 beats buffered, assert rst_ni=0 for 1 cycle -> count_o=0, master_valid_o=0. A new 4-beat burst afterward is delivered intact with no stale beats.
